// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter sharing one registered output stage between NUM_REQ
// valid/ready requesters; the captured word is held until the consumer takes it.
module dff_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [ID_W-1:0]          out_id,
    input  logic                     out_ready
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [PW-1:0]    ptr_q, ptr_d;

    logic               can_load;
    logic               gnt_any;
    logic [PW-1:0]      gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic [WIDTH-1:0]   data_sel;
    logic [PW:0]        scan_sum;
    logic [PW-1:0]      scan_idx;

    assign can_load = (state_q == EMPTY) || out_ready;

    // Scan from ptr upward with wrap; first valid requester wins.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (scan_sum >= (PW+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (PW+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[PW-1:0];
            if (!gnt_any && req_valid[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        gnt_any = gnt_any && can_load && rst_n;
    end

    always_comb begin
        gnt      = '0;
        data_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_any && gnt_idx == PW'(i)) begin
                gnt[i]   = 1'b1;
                data_sel = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        if (gnt_any) begin
            state_d = FULL;
            data_d  = data_sel;
            id_d    = ID_W'(gnt_idx);
            if (gnt_idx == PW'(NUM_REQ-1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + 1'b1;
            end
        end else if (out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign req_ready = gnt;
    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Bench for dff_share_arbiter: directed scenarios plus random traffic,
// with a reference grant model and an output scoreboard.
module tb_dff_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        out_ready;

    int n_vec;
    int n_bad;

    logic [9:0] exp_q[$];
    logic [9:0] exp_w;
    int         ptr_m;
    logic       full_m;
    logic [3:0] eg;
    int         gi;
    int         jj;

    int seq_id[6] = '{0, 1, 2, 3, 0, 1};

    dff_share_arbiter #(
        .NUM_REQ(4),
        .WIDTH  (8),
        .ID_W   (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_id   (out_id),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp,
                     $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model evaluated mid-cycle, when inputs are settled.
    always @(negedge clk) begin
        eg = '0;
        gi = -1;
        if (rst_n && (!full_m || out_ready)) begin
            for (int k = 0; k < 4; k++) begin
                jj = (ptr_m + k) % 4;
                if (gi < 0 && req_valid[jj]) gi = jj;
            end
        end
        if (gi >= 0) eg[gi] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(eg));
        chk("out_valid", 32'(out_valid), 32'(full_m));
        if (!rst_n) begin
            full_m = 1'b0;
            ptr_m  = 0;
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'(1), 32'(0));
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("out_word", 32'({out_id, out_data}), 32'(exp_w));
                end
            end
            if (gi >= 0) begin
                exp_q.push_back({2'(gi), req_data[gi*8 +: 8]});
                full_m = 1'b1;
                ptr_m  = (gi + 1) % 4;
            end else if (out_ready) begin
                full_m = 1'b0;
            end
        end
    end

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        ptr_m     = 0;
        full_m    = 1'b0;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_data  = '0;
        out_ready = 1'b0;

        // reset with all requesters active
        repeat (2) tick();
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_data", 32'(out_data), 32'(0));
        chk("rst_id", 32'(out_id), 32'(0));
        chk("rst_ready", 32'(req_ready), 32'(0));

        // single request
        rst_n     = 1'b1;
        req_valid = 4'b0100;
        req_data  = 32'h00A5_0000;
        out_ready = 1'b1;
        #1;
        chk("single_ready", 32'(req_ready), 32'h4);
        tick();
        chk("single_valid", 32'(out_valid), 32'(1));
        chk("single_data", 32'(out_data), 32'hA5);
        chk("single_id", 32'(out_id), 32'(2));
        req_valid = 4'b0000;
        tick();
        rst_n = 1'b0;
        tick();

        // round-robin with no bubbles
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        req_data  = 32'h1312_1110;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_valid", 32'(out_valid), 32'(1));
            chk("rr_id", 32'(out_id), 32'(seq_id[k]));
        end

        // backpressure holding id 1 / 0x11
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", 32'(out_valid), 32'(1));
            chk("bp_data", 32'(out_data), 32'h11);
            chk("bp_id", 32'(out_id), 32'(1));
            chk("bp_ready", 32'(req_ready), 32'(0));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_next_gnt", 32'(req_ready), 32'h4);
        tick();
        chk("bp_next_id", 32'(out_id), 32'(2));

        // idle and drain, priority must stay at 3
        req_valid = 4'b0000;
        tick();
        chk("drain_valid", 32'(out_valid), 32'(0));
        tick();
        req_valid = 4'b1001;
        #1;
        chk("idle_ptr", 32'(req_ready), 32'h8);
        tick();
        chk("idle_id3", 32'(out_id), 32'(3));
        req_valid = 4'b0001;
        tick();
        chk("wrap_id0", 32'(out_id), 32'(0));

        // reset while full with a grant pending
        req_valid = 4'b1111;
        tick();
        chk("pre_rst_id", 32'(out_id), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'(0));
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_data", 32'(out_data), 32'(0));
        rst_n = 1'b1;
        tick();
        chk("post_rst_id", 32'(out_id), 32'(0));
        chk("post_rst_data", 32'(out_data), 32'h10);

        // random traffic checked by the model
        for (int c = 0; c < 400; c++) begin
            rst_n     = ($urandom_range(0, 59) != 0);
            req_valid = 4'($urandom);
            req_data  = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        rst_n     = 1'b1;
        req_valid = 4'b0000;
        out_ready = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
